// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: FSM state encoding and the
// default operand width used by the arithmetic blocks.
package calc_pkg;

    localparam int CALC_WIDTH = 32'sd8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_e;

endpackage

// File: rtl/fulladder.sv
// Gate-level one-bit full adder cell, shared by the bit-serial arithmetic.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ab_x_s;

    assign ab_x_s = a ^ b;
    assign s      = ab_x_s ^ cin;
    assign cout   = (a & b) | (cin & ab_x_s);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop,
// processing operands LSB first, one bit per clock. Results (sum, cout,
// ovf) are registered at the last bit and held until the next operation.
// Build option: define SERIAL_ADDER_SUB_EN to enable subtraction (a - b);
// without it the sub input is ignored and the block is add-only.
module serial_adder
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_r;
    state_e             next_state_s;
    logic               accept_s;
    logic               last_bit_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-2:0]   res_sh_r;
    logic [WIDTH-1:0]   res_full_s;
    logic               carry_r;
    logic               carry_load_s;
    logic               b_in_s;
    logic               fa_sum_s;
    logic               fa_cout_s;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;
    logic               busy_r;
    logic               done_r;

`ifdef SERIAL_ADDER_SUB_EN
    logic               sub_q_r;

    // Capture the operation select with the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_q_r <= 1'b0;
        end else if (accept_s) begin
            sub_q_r <= sub;
        end else begin
            sub_q_r <= sub_q_r;
        end
    end

    // Subtract as a + ~b + 1: invert B per bit, preload the carry with sub.
    assign b_in_s       = b_sh_r[0] ^ sub_q_r;
    assign carry_load_s = sub;
`else
    logic               unused_sub_s;

    assign unused_sub_s = sub;
    assign b_in_s       = b_sh_r[0];
    assign carry_load_s = 1'b0;
`endif

    fulladder u_fa (
        .a    (a_sh_r[0]),
        .b    (b_in_s),
        .cin  (carry_r),
        .s    (fa_sum_s),
        .cout (fa_cout_s)
    );

    // New sum bit enters at the MSB; the full word is complete on the last bit.
    assign res_full_s = {fa_sum_s, res_sh_r};

    // Next-state decode; a start in IDLE or DONE is accepted, in RUN it is dropped.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        last_bit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_RUN;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    last_bit_s   = 1'b1;
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    next_state_s = ST_RUN;
                    accept_s     = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == ST_RUN);
            done_r  <= (next_state_s == ST_DONE);
        end
    end

    // Operand shift registers, partial result, carry and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            res_sh_r <= {(WIDTH-1){1'b0}};
            carry_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            a_sh_r   <= a;
            b_sh_r   <= b;
            res_sh_r <= {(WIDTH-1){1'b0}};
            carry_r  <= carry_load_s;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (state_r == ST_RUN) begin
            a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
            b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
            res_sh_r <= res_full_s[WIDTH-1:1];
            carry_r  <= fa_cout_s;
            cnt_r    <= last_bit_s ? {CNT_W{1'b0}} : (cnt_r + CNT_ONE);
        end else begin
            a_sh_r   <= a_sh_r;
            b_sh_r   <= b_sh_r;
            res_sh_r <= res_sh_r;
            carry_r  <= carry_r;
            cnt_r    <= cnt_r;
        end
    end

    // Result registers update only on the last bit; carry_r is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (last_bit_s) begin
            sum_r  <= res_full_s;
            cout_r <= fa_cout_s;
            ovf_r  <= carry_r ^ fa_cout_s;
        end else begin
            sum_r  <= sum_r;
            cout_r <= cout_r;
            ovf_r  <= ovf_r;
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=4, using a
// plain-arithmetic reference model (integer add/subtract, signed range test).
module tb_serial_adder;

    logic       clk_s = 1'b0;

    logic       rst8_s, start8_s, sub8_s;
    logic [7:0] a8_s, b8_s, sum8_s;
    logic       cout8_s, ovf8_s, busy8_s, done8_s;

    logic       rst4_s, start4_s, sub4_s;
    logic [3:0] a4_s, b4_s, sum4_s;
    logic       cout4_s, ovf4_s, busy4_s, done4_s;

    int         checks_total  = 0;
    int         checks_passed = 0;

    int         exp_sum8  = 0;
    int         exp_cout8 = 0;
    int         exp_ovf8  = 0;
    int         exp_sum4  = 0;
    int         exp_cout4 = 0;
    int         exp_ovf4  = 0;

    always #5 clk_s = ~clk_s;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk_s), .rst(rst8_s), .start(start8_s), .sub(sub8_s),
        .a(a8_s), .b(b8_s), .sum(sum8_s), .cout(cout8_s), .ovf(ovf8_s),
        .busy(busy8_s), .done(done8_s)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk_s), .rst(rst4_s), .start(start4_s), .sub(sub4_s),
        .a(a4_s), .b(b4_s), .sum(sum4_s), .cout(cout4_s), .ovf(ovf4_s),
        .busy(busy4_s), .done(done4_s)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks_total++;
        if (got == exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: unsigned sum/carry from integer arithmetic, overflow from
    // whether the signed result leaves the w-bit two's complement range.
    function automatic void ref_add(input int w, input int ai, input int bi, input int subi,
                                    output int s, output int c, output int o);
        int es, mask, half, t, sa, sb, r;
`ifdef SERIAL_ADDER_SUB_EN
        es = subi;
`else
        es = 0;
`endif
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        if (es != 0) t = ai + ((~bi) & mask) + 1;
        else         t = ai + bi;
        s  = t & mask;
        c  = (t >> w) & 1;
        sa = (ai >= half) ? ai - (1 << w) : ai;
        sb = (bi >= half) ? bi - (1 << w) : bi;
        r  = (es != 0) ? sa - sb : sa + sb;
        o  = ((r < -half) || (r > half - 1)) ? 1 : 0;
    endfunction

    // One WIDTH=8 operation; optionally re-pulse start at busy cycle poke_k.
    task automatic op8(input string tag, input int ai, input int bi, input int subi, input int poke_k);
        int s, c, o;
        ref_add(8, ai, bi, subi, s, c, o);
        start8_s = 1'b1;
        a8_s     = 8'(ai);
        b8_s     = 8'(bi);
        sub8_s   = subi[0];
        @(posedge clk_s); #1;
        for (int k = 1; k <= 8; k++) begin
            if (k == poke_k) begin
                start8_s = 1'b1;
                a8_s     = ~a8_s;
                b8_s     = b8_s + 8'd37;
                sub8_s   = ~sub8_s;
            end else begin
                start8_s = 1'b0;
                a8_s     = 8'($urandom);
                b8_s     = 8'($urandom);
            end
            check_eq({tag, "_busy"}, int'(busy8_s), 1);
            check_eq({tag, "_done_early"}, int'(done8_s), 0);
            check_eq({tag, "_sum_held"}, int'(sum8_s), exp_sum8);
            check_eq({tag, "_cout_held"}, int'(cout8_s), exp_cout8);
            @(posedge clk_s); #1;
        end
        start8_s = 1'b0;
        check_eq({tag, "_done"}, int'(done8_s), 1);
        check_eq({tag, "_busy_off"}, int'(busy8_s), 0);
        check_eq({tag, "_sum"}, int'(sum8_s), s);
        check_eq({tag, "_cout"}, int'(cout8_s), c);
        check_eq({tag, "_ovf"}, int'(ovf8_s), o);
        exp_sum8  = s;
        exp_cout8 = c;
        exp_ovf8  = o;
        @(posedge clk_s); #1;
        check_eq({tag, "_done_pulse"}, int'(done8_s), 0);
        check_eq({tag, "_idle_busy"}, int'(busy8_s), 0);
        check_eq({tag, "_sum_keep"}, int'(sum8_s), exp_sum8);
    endtask

    // One WIDTH=4 operation with the latency check at start+5.
    task automatic op4(input string tag, input int ai, input int bi, input int subi);
        int s, c, o;
        ref_add(4, ai, bi, subi, s, c, o);
        start4_s = 1'b1;
        a4_s     = 4'(ai);
        b4_s     = 4'(bi);
        sub4_s   = subi[0];
        @(posedge clk_s); #1;
        start4_s = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check_eq({tag, "_busy"}, int'(busy4_s), 1);
            check_eq({tag, "_done_early"}, int'(done4_s), 0);
            check_eq({tag, "_sum_held"}, int'(sum4_s), exp_sum4);
            @(posedge clk_s); #1;
        end
        check_eq({tag, "_done"}, int'(done4_s), 1);
        check_eq({tag, "_sum"}, int'(sum4_s), s);
        check_eq({tag, "_cout"}, int'(cout4_s), c);
        check_eq({tag, "_ovf"}, int'(ovf4_s), o);
        exp_sum4  = s;
        exp_cout4 = c;
        exp_ovf4  = o;
        @(posedge clk_s); #1;
        check_eq({tag, "_done_pulse"}, int'(done4_s), 0);
    endtask

    initial begin
        int s1, c1, o1, s2, c2, o2;
        rst8_s = 1'b1; start8_s = 1'b0; sub8_s = 1'b0; a8_s = 8'd0; b8_s = 8'd0;
        rst4_s = 1'b1; start4_s = 1'b0; sub4_s = 1'b0; a4_s = 4'd0; b4_s = 4'd0;
        repeat (2) @(posedge clk_s);
        #1;
        check_eq("rst_sum8", int'(sum8_s), 0);
        check_eq("rst_cout8", int'(cout8_s), 0);
        check_eq("rst_ovf8", int'(ovf8_s), 0);
        check_eq("rst_busy8", int'(busy8_s), 0);
        check_eq("rst_done8", int'(done8_s), 0);
        check_eq("rst_sum4", int'(sum4_s), 0);
        check_eq("rst_busy4", int'(busy4_s), 0);
        rst8_s = 1'b0;
        rst4_s = 1'b0;
        @(posedge clk_s); #1;

        // Directed cases from the operating examples.
        op8("add_100_27", 100, 27, 0, 0);
        op8("add_200_100", 200, 100, 0, 0);
        op8("add_100_50", 100, 50, 0, 0);
        op8("sub_5_9", 5, 9, 1, 0);
        op8("start_ignored", 30, 40, 0, 4);

        // Reset in the middle of an operation.
        start8_s = 1'b1; a8_s = 8'd50; b8_s = 8'd60; sub8_s = 1'b0;
        @(posedge clk_s); #1;
        start8_s = 1'b0;
        repeat (2) @(posedge clk_s);
        #1;
        rst8_s = 1'b1;
        @(posedge clk_s); #1;
        rst8_s = 1'b0;
        check_eq("midrst_sum", int'(sum8_s), 0);
        check_eq("midrst_cout", int'(cout8_s), 0);
        check_eq("midrst_ovf", int'(ovf8_s), 0);
        check_eq("midrst_busy", int'(busy8_s), 0);
        check_eq("midrst_done", int'(done8_s), 0);
        exp_sum8 = 0; exp_cout8 = 0; exp_ovf8 = 0;
        @(posedge clk_s); #1;
        check_eq("midrst_idle", int'(busy8_s), 0);
        op8("after_rst", 1, 1, 0, 0);

        // Start held high across two back-to-back operations.
        ref_add(8, 3, 4, 0, s1, c1, o1);
        ref_add(8, 10, 20, 0, s2, c2, o2);
        start8_s = 1'b1; a8_s = 8'd3; b8_s = 8'd4; sub8_s = 1'b0;
        @(posedge clk_s); #1;
        for (int k = 1; k <= 18; k++) begin
            if (k == 1) begin
                a8_s = 8'd10;
                b8_s = 8'd20;
            end
            if (k == 9) begin
                check_eq("hold_done1", int'(done8_s), 1);
                check_eq("hold_sum1", int'(sum8_s), s1);
            end else if (k == 18) begin
                check_eq("hold_done2", int'(done8_s), 1);
                check_eq("hold_sum2", int'(sum8_s), s2);
                check_eq("hold_cout2", int'(cout8_s), c2);
                check_eq("hold_ovf2", int'(ovf8_s), o2);
                start8_s = 1'b0;
            end else begin
                check_eq("hold_busy", int'(busy8_s), 1);
                check_eq("hold_done_low", int'(done8_s), 0);
            end
            @(posedge clk_s); #1;
        end
        exp_sum8 = s2; exp_cout8 = c2; exp_ovf8 = o2;
        check_eq("hold_end_idle", int'(busy8_s), 0);

        // Randomised operations, both operations and all operand ranges.
        for (int i = 0; i < 16; i++) begin
            op8("rand8", int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 1)), (i % 4 == 0) ? int'($urandom_range(1, 8)) : 0);
        end

        // Narrow configuration.
        op4("w4_7_1", 7, 1, 0);
        for (int i = 0; i < 8; i++) begin
            op4("rand4", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
